sound_ram_reader: RTL

//  CPU read-back path for the GLU's dedicated 64K sound RAM; the write-side counterpart is the GLU data-register write path.
//  On a CPU read of $C03D with control bit 6 set (RAM access), drives the byte fetched by the previous read.
//  It then issues an SDRAM read at the current pointer and latches the result for the next read.

---
 rtl/sound_ram_reader.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sound_ram_reader.sv
// CPU read-back of the GLU sound RAM through $C03D with dummy-read semantics:
// each read returns the byte fetched by the previous one, then launches the next fetch.
module sound_ram_reader #(
    parameter logic ENABLE         = 1'b1,
    parameter int   TIMEOUT_CYCLES = 64
) (
    input  logic        clk_logic,
    input  logic        system_reset_n,
    input  logic        phi0_i,
    input  logic [15:0] addr_i,
    input  logic        rw_n_i,
    input  logic        m2sel_n_i,
    input  logic        data_in_strobe_i,
    input  logic        access_ram_i,
    input  logic        auto_inc_i,
    input  logic [15:0] sound_ptr_i,
    output logic [7:0]  data_o,
    output logic        rd_en_o,
    output logic        ptr_inc_o,
    output logic        mem_rd_o,
    output logic [20:0] mem_addr_o,
    input  logic [31:0] mem_q_i,
    input  logic        mem_ready_i,
    output logic        busy_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    localparam int            TW     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [7:0]    rbuf_q, rbuf_d;
    logic [15:0]   fptr_q, fptr_d;
    logic [15:0]   pend_ptr_q, pend_ptr_d;
    logic          pend_q, pend_d;
    logic [1:0]    off_q, off_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          timeout_q, timeout_d;

    logic sel, rd_stb;

    assign sel    = ENABLE & phi0_i & ~m2sel_n_i & (addr_i == 16'hC03D) & rw_n_i & access_ram_i;
    assign rd_stb = sel & data_in_strobe_i;

    always_ff @(posedge clk_logic) begin
        if (!system_reset_n) begin
            state_q    <= S_IDLE;
            rbuf_q     <= 8'h00;
            fptr_q     <= 16'h0000;
            pend_ptr_q <= 16'h0000;
            pend_q     <= 1'b0;
            off_q      <= 2'b00;
            timer_q    <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rbuf_q     <= rbuf_d;
            fptr_q     <= fptr_d;
            pend_ptr_q <= pend_ptr_d;
            pend_q     <= pend_d;
            off_q      <= off_d;
            timer_q    <= timer_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rbuf_d     = rbuf_q;
        fptr_d     = fptr_q;
        pend_ptr_d = pend_ptr_q;
        pend_d     = pend_q;
        off_d      = off_q;
        timer_d    = timer_q;
        timeout_d  = timeout_q;

        // A read while a fetch is in flight is queued one deep; newest pointer wins.
        if (rd_stb && state_q != S_IDLE) begin
            pend_d     = 1'b1;
            pend_ptr_d = sound_ptr_i;
        end

        case (state_q)
            S_IDLE: begin
                if (rd_stb) begin
                    fptr_d  = sound_ptr_i;
                    pend_d  = 1'b0;
                    state_d = S_REQ;
                end else if (pend_q) begin
                    fptr_d  = pend_ptr_q;
                    pend_d  = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                off_d   = fptr_q[1:0];
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_ready_i) begin
                    rbuf_d  = mem_q_i[{off_q, 3'b000} +: 8];
                    state_d = S_IDLE;
                end else if (timer_q == T_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign data_o     = rbuf_q;
    assign rd_en_o    = sel;
    assign ptr_inc_o  = rd_stb & auto_inc_i & system_reset_n;
    assign mem_rd_o   = ENABLE & (state_q == S_REQ) & system_reset_n;
    assign mem_addr_o = {4'b0000, 1'b1, 2'b00, fptr_q[15:2]};
    assign busy_o     = (state_q != S_IDLE) | pend_q;
    assign timeout_o  = timeout_q;

endmodule
